// File: rtl/orb_serializer_if.sv
// Read port between the serializer and the frame RAM.
//   RdAddr  master->slave  word address
//   RE      master->slave  1-cycle read strobe
//   rdData  slave->master  read data, valid a fixed latency after RE
interface orb_serializer_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 11
);
  logic [ADDR_W-1:0] RdAddr;
  logic              RE;
  logic [DATA_W-1:0] rdData;

  modport master (output RdAddr, output RE, input rdData);
  modport slave  (input RdAddr, input RE, output rdData);
endinterface

// File: rtl/orb_serializer.sv
// Frame RAM reader: fetches words sequentially and shifts them out MSB-first
// with bit/word/frame strobes; toggles the buffer select SW on each frame wrap.
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous reset, active-low
//   en         run enable level (synchronised internally)
//   ram        RAM read port (RdAddr, RE out; rdData in)
//   serOut     serial data, MSB first
//   bitStrb    pulse on the first clk of each bit period
//   wordStrb   pulse with the first bitStrb of each word
//   frameStrb  pulse in the cycle RdAddr wraps to 0
//   SW         buffer select, toggles at each wrap
module orb_serializer #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned BIT_DIV = 8,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  orb_serializer_if.master    ram,
  output logic                serOut,
  output logic                bitStrb,
  output logic                wordStrb,
  output logic                frameStrb,
  output logic                SW
);

  localparam int unsigned DIV_W = $clog2(BIT_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SHIFT} state_t;

  state_t              state, state_d;
  logic                en_meta, en_s;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sw_d, frame_d;

  assign ram.RdAddr = addr_q;

  // Two-flop synchroniser for the asynchronous run enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      en_meta <= en;
      en_s    <= en_meta;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    div_d   = div_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    shreg_d = shreg;
    addr_d  = addr_q;
    sw_d    = SW;
    frame_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en_s) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Last wait cycle is exactly RD_LAT cycles after RE: data is valid now
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          shreg_d = ram.rdData;
          bit_d   = '0;
          div_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_W'(BIT_DIV - 1)) begin
          div_d   = '0;
          shreg_d = {shreg[DATA_W-2:0], 1'b0};
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == {ADDR_W{1'b1}}) begin
              sw_d    = ~SW;
              frame_d = 1'b1;
            end
            state_d = en_s ? ST_FETCH : ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the
  // next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      lat_q     <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      ram.RE    <= 1'b0;
      serOut    <= 1'b0;
      bitStrb   <= 1'b0;
      wordStrb  <= 1'b0;
      frameStrb <= 1'b0;
      SW        <= 1'b0;
    end else begin
      state     <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      lat_q     <= lat_d;
      shreg     <= shreg_d;
      addr_q    <= addr_d;
      ram.RE    <= (state_d == ST_FETCH);
      serOut    <= (state_d == ST_SHIFT) && shreg_d[DATA_W-1];
      bitStrb   <= (state_d == ST_SHIFT) && (div_d == '0);
      wordStrb  <= (state_d == ST_SHIFT) && (div_d == '0) && (bit_d == '0);
      frameStrb <= frame_d;
      SW        <= sw_d;
    end
  end

endmodule

// File: tb/tb_orb_serializer.sv
// Directed bench: DUT a uses default parameters, DUT b a small frame with
// BIT_DIV=4, RD_LAT=1 so frame wraps fit in a short run.
module tb_orb_serializer;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b;
  logic a_ser, a_bs, a_ws, a_fs, a_sw;
  logic b_ser, b_bs, b_ws, b_fs, b_sw;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  orb_serializer_if #(.DATA_W(12), .ADDR_W(11)) a_if ();
  orb_serializer_if #(.DATA_W(12), .ADDR_W(3))  b_if ();

  orb_serializer #(.DATA_W(12), .ADDR_W(11), .BIT_DIV(8), .RD_LAT(2)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .ram(a_if),
    .serOut(a_ser), .bitStrb(a_bs), .wordStrb(a_ws), .frameStrb(a_fs), .SW(a_sw)
  );

  orb_serializer #(.DATA_W(12), .ADDR_W(3), .BIT_DIV(4), .RD_LAT(1)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .ram(b_if),
    .serOut(b_ser), .bitStrb(b_bs), .wordStrb(b_ws), .frameStrb(b_fs), .SW(b_sw)
  );

  // RAM models; junk on rdData outside the valid cycle
  logic [11:0] mem_a [2048];
  logic [11:0] mem_b [8];
  logic [11:0] a_p0, a_p1, b_p0;

  always @(posedge clk) begin
    a_p0 <= a_if.RE ? mem_a[a_if.RdAddr] : 12'hBAD;
    a_p1 <= a_p0;
    b_p0 <= b_if.RE ? mem_b[b_if.RdAddr] : 12'h5A5;
  end
  assign a_if.rdData = a_p1;
  assign b_if.rdData = b_p0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_re(input bit sel, input int budget, output int n);
    n = 0;
    while (!(sel ? b_if.RE : a_if.RE) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "re_timeout_b" : "re_timeout_a", 32'(sel ? b_if.RE : a_if.RE), 32'd1);
  endtask

  // Called on the first SHIFT cycle; returns on the cycle after the word
  task automatic capture(input bit sel, input int ndiv, input int drop_at,
                         output logic [11:0] word, output int nbit, output int nword,
                         output int nhigh, output int nre);
    logic s;
    word = '0; nbit = 0; nword = 0; nhigh = 0; nre = 0;
    for (int k = 0; k < 12 * ndiv; k++) begin
      if (k == drop_at) en_a = 1'b0;
      s = sel ? b_ser : a_ser;
      if (k % ndiv == 0) word = {word[10:0], s};
      if (sel ? b_bs : a_bs) nbit++;
      if (sel ? b_ws : a_ws) nword++;
      if (s) nhigh++;
      if (sel ? b_if.RE : a_if.RE) nre++;
      @(negedge clk);
    end
  endtask

  logic [11:0] w;
  int n, nbit, nword, nhigh, nre, errs, gap, gap_err, nfs, fs_err;
  logic sw399, sw400, sw799, sw800;

  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    for (int i = 0; i < 2048; i++) mem_a[i] = 12'(i * 37 + 12'h3C5);
    mem_a[0] = 12'hA5C;
    for (int i = 0; i < 8; i++) mem_b[i] = 12'(i * 12'h123 + 1);
    mem_b[0] = 12'hFFF;

    // Reset held while en toggles
    repeat (3) @(negedge clk);
    en_a = 1'b1; en_b = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_outs_a", 32'({a_if.RdAddr, a_if.RE, a_ser, a_bs, a_ws, a_fs, a_sw}), 32'd0);
    check("rst_outs_b", 32'({b_if.RdAddr, b_if.RE, b_ser, b_bs, b_ws, b_fs, b_sw}), 32'd0);
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nre = 0;
    repeat (20) begin @(negedge clk); if (a_if.RE || a_ser || a_bs) nre++; end
    check("idle_quiet", 32'(nre), 32'd0);
    check("idle_addr", 32'(a_if.RdAddr), 32'd0);

    // First word 0xA5C
    en_a = 1'b1;
    wait_re(1'b0, 20, n);
    check("w0_re_addr", 32'(a_if.RdAddr), 32'd0);
    @(negedge clk);
    check("w0_re_pulse", 32'(a_if.RE), 32'd0);
    @(negedge clk);
    check("w0_wait_quiet", 32'({a_ser, a_bs}), 32'd0);
    @(negedge clk);
    check("w0_first_strobes", 32'({a_bs, a_ws}), 32'd3);
    capture(1'b0, 8, -1, w, nbit, nword, nhigh, nre);
    check("w0_word", 32'(w), 32'h0A5C);
    check("w0_bitstrb_cnt", 32'(nbit), 32'd12);
    check("w0_wordstrb_cnt", 32'(nword), 32'd1);
    check("w0_high_clks", 32'(nhigh), 32'd48);
    check("w0_no_re_in_shift", 32'(nre), 32'd0);
    check("w0_period99", 32'(a_if.RE), 32'd1);
    check("w0_next_addr", 32'(a_if.RdAddr), 32'd1);

    // Words 1..9 back to back, each 99 clk apart
    errs = 0;
    for (int i = 1; i < 10; i++) begin
      repeat (3) @(negedge clk);
      capture(1'b0, 8, -1, w, nbit, nword, nhigh, nre);
      if (w !== mem_a[i] || a_if.RE !== 1'b1 || a_if.RdAddr !== 11'(i + 1) || nbit != 12) errs++;
    end
    check("words_1_9", 32'(errs), 32'd0);

    // Drop en at bit 5 of word 10
    repeat (3) @(negedge clk);
    capture(1'b0, 8, 40, w, nbit, nword, nhigh, nre);
    check("drop_word_complete", 32'(w), 32'(mem_a[10]));
    check("drop_bits", 32'(nbit), 32'd12);
    check("drop_idle_re", 32'(a_if.RE), 32'd0);
    check("drop_addr", 32'(a_if.RdAddr), 32'd11);
    nre = 0;
    repeat (30) begin @(negedge clk); if (a_if.RE || a_ser || a_bs) nre++; end
    check("drop_idle_quiet", 32'(nre), 32'd0);
    en_a = 1'b1;
    wait_re(1'b0, 20, n);
    check("resume_addr", 32'(a_if.RdAddr), 32'd11);

    // Reset in the middle of bit 7 of word 11
    repeat (3 + 59) @(negedge clk);
    check("pre_rst_bs_low", 32'(a_bs), 32'd0);
    rst = 1'b0;
    #1;
    check("async_rst_outs", 32'({a_if.RdAddr, a_ser, a_sw, a_if.RE, a_bs, a_ws}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_re(1'b0, 20, n);
    check("post_rst_addr", 32'(a_if.RdAddr), 32'd0);
    repeat (3) @(negedge clk);
    capture(1'b0, 8, -1, w, nbit, nword, nhigh, nre);
    check("post_rst_word", 32'(w), 32'h0A5C);
    en_a = 1'b0;

    // Small DUT: 0xFFF high for 48 clk, 50 clk period
    en_b = 1'b1;
    wait_re(1'b1, 20, n);
    check("b_re_addr", 32'(b_if.RdAddr), 32'd0);
    @(negedge clk);
    check("b_wait_bs", 32'(b_bs), 32'd0);
    @(negedge clk);
    check("b_first_strobes", 32'({b_bs, b_ws}), 32'd3);
    capture(1'b1, 4, -1, w, nbit, nword, nhigh, nre);
    check("b_word", 32'(w), 32'h0FFF);
    check("b_high_clks", 32'(nhigh), 32'd48);
    check("b_period50", 32'(b_if.RE), 32'd1);
    check("b_next_addr", 32'(b_if.RdAddr), 32'd1);

    // Two frame wraps: RE of word 0 was cycle 0, now at cycle 50
    gap = 0; gap_err = 0; nre = 0; nfs = 0; fs_err = 0;
    sw399 = 1'bx; sw400 = 1'bx; sw799 = 1'bx; sw800 = 1'bx;
    for (int c = 51; c <= 800; c++) begin
      @(negedge clk);
      gap++;
      if (b_if.RE) begin
        if (gap != 50) gap_err++;
        gap = 0;
        nre++;
      end
      if (b_fs) begin
        nfs++;
        if (b_if.RdAddr !== 3'd0) fs_err++;
      end
      if (c == 399) sw399 = b_sw;
      if (c == 400) sw400 = b_sw;
      if (c == 799) sw799 = b_sw;
      if (c == 800) sw800 = b_sw;
    end
    check("wrap_re_count", 32'(nre), 32'd15);
    check("wrap_spacing", 32'(gap_err), 32'd0);
    check("wrap_frame_cnt", 32'(nfs), 32'd2);
    check("wrap_frame_addr", 32'(fs_err), 32'd0);
    check("wrap_sw_sequence", 32'({sw399, sw400, sw799, sw800}), 32'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
